// File: rtl/ahfp_float_2_fixed.sv
// Purpose : IEEE-754 single-precision to signed fixed-point (FRAC_BITS fractional bits) converter.
// Latency : 2 cycles, fully pipelined, one result per cycle when the output is drained every cycle.
// Backpr. : in_ready = !out_valid || out_ready; both stages freeze while a result waits unconsumed.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset, flushes both stages
//   in         - float operand {sign, exp[7:0], man[22:0]}
//   in_valid   - operand on `in` is valid
//   in_ready   - operand is accepted this cycle; also the advance enable of the pipeline
//   out        - two's-complement fixed-point result
//   out_valid  - out/ovf are valid
//   out_ready  - downstream accepts the result
//   ovf        - result saturated, or the operand was NaN
//
// Build option: define AHFP_F2X_ROUND_EN to round to nearest, ties-to-even, instead of
// truncating toward zero. Latency and handshake are identical in both builds.

module ahfp_float_2_fixed #(
    parameter int FRAC_BITS = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ovf
);

    // ------------------------------------------------------------------
    // Stage 1: decode and align the magnitude
    // ------------------------------------------------------------------
    logic              s1_vld_q;
    logic              s1_sign_q, s1_sign_d;
    logic              s1_nan_q,  s1_nan_d;
    logic              s1_big_q,  s1_big_d;   // magnitude certainly above 2^31 (or infinity)
    logic [31:0]       s1_mag_q,  s1_mag_d;   // aligned magnitude, may equal 2^31 exactly

    logic [7:0]        exp_w;
    logic [22:0]       man_w;
    logic [23:0]       sig_w;
    logic signed [9:0] k_w;
    logic signed [9:0] rdiff_w;
    logic [3:0]        lsh_w;
    logic [5:0]        rsh_w;

    assign exp_w   = in[30:23];
    assign man_w   = in[22:0];
    assign sig_w   = {1'b1, man_w};
    // k is the bit position of the hidden 1 in the fixed-point result.
    assign k_w     = $signed({2'b00, exp_w}) - 10'sd127 + $signed(10'(FRAC_BITS));
    assign rdiff_w = 10'sd23 - k_w;
    assign lsh_w   = 4'(k_w - 10'sd23);
    // Any right shift of 48 or more leaves nothing, not even a guard bit.
    assign rsh_w   = (rdiff_w > 10'sd48) ? 6'd48 : 6'(rdiff_w);

`ifdef AHFP_F2X_ROUND_EN
    logic [47:0] ext_w;
    logic        rnd_w;
    // Keep the shifted-out bits below the integer part: [23] is guard, [22:0] fold into sticky.
    assign ext_w = {sig_w, 24'b0} >> rsh_w;
    assign rnd_w = ext_w[23] & ((|ext_w[22:0]) | ext_w[24]);
`endif

    always_comb begin
        s1_sign_d = in[31];
        s1_nan_d  = 1'b0;
        s1_big_d  = 1'b0;
        s1_mag_d  = '0;
        if (exp_w == 8'd0) begin
            // zero and denormals flush to 0
            s1_mag_d = '0;
        end else if (exp_w == 8'hFF) begin
            s1_nan_d = (man_w != 23'd0);
            s1_big_d = (man_w == 23'd0);
        end else if (k_w > 10'sd31) begin
            s1_big_d = 1'b1;
        end else if (k_w >= 10'sd23) begin
            // k == 31 lands the hidden 1 on bit 31; stage 2 separates exact -2^31 from overflow.
            s1_mag_d = {8'b0, sig_w} << lsh_w;
        end else begin
`ifdef AHFP_F2X_ROUND_EN
            s1_mag_d = {8'b0, ext_w[47:24]} + {31'b0, rnd_w};
`else
            s1_mag_d = {8'b0, sig_w >> rsh_w};
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturate, apply sign, register the result
    // ------------------------------------------------------------------
    logic        out_vld_q;
    logic [31:0] out_q, out_d;
    logic        ovf_q, ovf_d;

    always_comb begin
        out_d = '0;
        ovf_d = 1'b0;
        if (s1_vld_q) begin
            if (s1_nan_q) begin
                ovf_d = 1'b1;
            end else if (s1_big_q || s1_mag_q[31]) begin
                if (s1_sign_q && !s1_big_q && (s1_mag_q == 32'h8000_0000)) begin
                    // -2^31 is representable
                    out_d = 32'h8000_0000;
                end else begin
                    out_d = s1_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    ovf_d = 1'b1;
                end
            end else begin
                // negating a zero magnitude yields 0, so -0 needs no special case
                out_d = s1_sign_q ? (~s1_mag_q + 32'd1) : s1_mag_q;
            end
        end
    end

    assign in_ready = !out_vld_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_nan_q  <= 1'b0;
            s1_big_q  <= 1'b0;
            s1_mag_q  <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
        end else if (in_ready) begin
            s1_vld_q  <= in_valid;
            s1_sign_q <= s1_sign_d;
            s1_nan_q  <= s1_nan_d;
            s1_big_q  <= s1_big_d;
            s1_mag_q  <= s1_mag_d;
            out_vld_q <= s1_vld_q;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out       = out_q;
    assign ovf       = ovf_q;
    assign out_valid = out_vld_q;

endmodule

// File: tb/tb_ahfp_float_2_fixed.sv
// Purpose : self-checking bench for ahfp_float_2_fixed (FRAC_BITS = 27).
// Latency : checks 2-cycle latency on directed, unstalled traffic.
// Backpr. : exercises random and forced out_ready stalls, plus mid-flight reset.

module tb_ahfp_float_2_fixed;

    localparam int FB = 27;

    logic        clk;
    logic        rst;
    logic [31:0] in_dat;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_dat;
    logic        out_valid;
    logic        out_ready;
    logic        ovf;

    ahfp_float_2_fixed #(.FRAC_BITS(FB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_dat),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out_dat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    typedef struct {
        logic [31:0] din;
        logic [31:0] eo;
        logic        ev;
        int          acc;
        bit          lat;
    } sb_t;

    sb_t sb[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc    = 0;
    int  mode   = 0;          // 0: out_ready=1, 1: random, 2: out_ready=0
    bit  sends_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- reference model ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic void model(input logic [31:0] f, output logic [31:0] o, output logic v);
        int   e;
        int   mag;
        logic s;
        real  mr;
        real  fl;
        real  d;
        e = int'(f[30:23]);
        s = f[31];
        o = 32'd0;
        v = 1'b0;
        if (e == 0) return;
        if (e == 255) begin
            v = 1'b1;
            if (f[22:0] == 23'd0) o = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            return;
        end
        // exact real value of |x| * 2^FB
        mr = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(e - 127 + FB);
        fl = $floor(mr);
`ifdef AHFP_F2X_ROUND_EN
        d = mr - fl;
        if (d > 0.5 || (d == 0.5 && (fl - 2.0 * $floor(fl / 2.0)) == 1.0)) fl = fl + 1.0;
`else
        d = 0.0;
`endif
        mr = fl + d * 0.0;
        if (mr > 2147483648.0 || (mr == 2147483648.0 && !s)) begin
            v = 1'b1;
            o = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (mr == 2147483648.0) begin
            o = 32'h8000_0000;
        end else begin
            mag = $rtoi(mr);
            o   = s ? -mag : mag;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic send(input logic [31:0] d, input logic [31:0] eo, input logic ev, input bit lat);
        int t = 0;
        @(negedge clk);
        in_dat   = d;
        in_valid = 1'b1;
        #1;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in=%h never accepted", d);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{din: d, eo: eo, ev: ev, acc: cyc, lat: lat});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [31:0] f;
        logic [31:0] eo;
        logic        ev;
        int          r;
        logic [7:0]  e;
        r = $urandom_range(0, 15);
        if (r == 0)      e = 8'd0;
        else if (r == 1) e = 8'hFF;
        else             e = 8'($urandom_range(90, 165));
        f = {1'($urandom_range(0, 1)), e, 23'($urandom)};
        if (r == 2) f[22:0] = 23'd0;
        model(f, eo, ev);
        send(f, eo, ev, 1'b0);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit          prev_stall = 1'b0;
    logic [31:0] hold_out;
    logic        hold_ovf;

    initial forever begin
        sb_t e;
        @(negedge clk);
        #1;
        n_chk++;
        if (in_ready !== (!out_valid || out_ready)) begin
            n_fail++;
            $display("FAIL in_ready_rule: in_ready=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
        end
        if (prev_stall) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_dat !== hold_out || ovf !== hold_ovf) begin
                n_fail++;
                $display("FAIL stall_hold: got vld=%b out=%h ovf=%b expected vld=1 out=%h ovf=%b",
                         out_valid, out_dat, ovf, hold_out, hold_ovf);
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: out=%h ovf=%b with nothing outstanding", out_dat, ovf);
            end else begin
                e = sb.pop_front();
                if (out_dat !== e.eo || ovf !== e.ev) begin
                    n_fail++;
                    $display("FAIL result in=%h: got out=%h ovf=%b expected out=%h ovf=%b",
                             e.din, out_dat, ovf, e.eo, e.ev);
                end
                if (e.lat) begin
                    n_chk++;
                    if (cyc - e.acc != 2) begin
                        n_fail++;
                        $display("FAIL latency in=%h: got %0d cycles expected 2", e.din, cyc - e.acc);
                    end
                end
            end
        end
        prev_stall = out_valid && !out_ready && !rst;
        hold_out   = out_dat;
        hold_ovf   = ovf;
    end

    // ---------------- main sequence ----------------
    initial begin
        int t;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_dat   = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out",       out_dat,            32'd0);
        check("reset_ovf",       {31'd0, ovf},       32'd0);
        check("reset_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back, unstalled, latency checked
        send(32'h3F80_0000, 32'h0800_0000, 1'b0, 1'b1);
        send(32'hBF80_0000, 32'hF800_0000, 1'b0, 1'b1);
        send(32'h3F00_0000, 32'h0400_0000, 1'b0, 1'b1);
        // saturation, infinity, NaN, denormal, tiny value
        send(32'h4180_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send(32'hC180_0000, 32'h8000_0000, 1'b0, 1'b1);
        send(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b1);
        send(32'h7FC0_0000, 32'h0000_0000, 1'b1, 1'b1);
        send(32'h0040_0000, 32'h0000_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1);
`ifdef AHFP_F2X_ROUND_EN
        send(32'h31C0_0000, 32'h0000_0001, 1'b0, 1'b1);
`else
        send(32'h31C0_0000, 32'h0000_0000, 1'b0, 1'b1);
`endif
        repeat (4) @(negedge clk);

        // three operands, output stalled for 4 cycles on the first result
        sends_done = 1'b0;
        fork
            begin
                send(32'h4000_0000, 32'h1000_0000, 1'b0, 1'b0);
                send(32'hC040_0000, 32'hE800_0000, 1'b0, 1'b0);
                send(32'h3E80_0000, 32'h0200_0000, 1'b0, 1'b0);
                sends_done = 1'b1;
            end
        join_none
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!out_valid && t < 50);
        check("stall_first_valid", {31'd0, out_valid}, 32'd1);
        mode = 2;
        repeat (4) @(posedge clk);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        #1 mode = 0;
        t = 0;
        while ((!sends_done || sb.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("stall_drained", 32'(sb.size()), 32'd0);

        // reset while two operands are in flight
        send(32'h3FC0_0000, 32'h0C00_0000, 1'b0, 1'b0);
        send(32'hC000_0000, 32'hF000_0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        check("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_reset_out",       out_dat,            32'd0);
        check("mid_reset_ovf",       {31'd0, ovf},       32'd0);
        check("mid_reset_in_ready",  {31'd0, in_ready},  32'd1);
        repeat (8) @(negedge clk);

        // randomized traffic with random backpressure
        mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_rand();
        end
        mode = 0;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("final_drained", 32'(sb.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahfp_float_2_fixed.md
AHFP_FLOAT_2_FIXED -- requirements
Module: ahfp_float_2_fixed

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 27: number of fractional bits of the fixed-point output, legal range 0..30.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in, input, 32 bits: IEEE-754 single-precision operand {sign, exp[7:0], man[22:0]}.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand on in is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the operand this cycle.
REQ-007 SHALL have port out, output, 32 bits: two's-complement fixed-point result with FRAC_BITS fractional bits.
REQ-008 SHALL have port out_valid, output, 1 bit: out and ovf are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-010 SHALL have port ovf, output, 1 bit: the result was saturated, or the input was NaN.

Function
REQ-011 SHALL be a 2-stage pipeline: stage 1 decodes and shifts the magnitude; stage 2 negates, saturates and registers out.
REQ-012 SHALL accept an operand on a cycle with in_valid && in_ready, and present its result with out_valid=1 two cycles later, given no stall.
REQ-013 SHALL drive in_ready = !out_valid || out_ready, combinationally; this signal is also the global advance enable for both stages.
REQ-014 SHALL hold out, ovf and out_valid stable, and both stages frozen, while out_valid && !out_ready.
REQ-015 SHALL sustain one result per cycle when out_ready is held at 1, with no bubbles inserted.
REQ-016 SHALL propagate a stage-valid bit; on an advance with in_valid=0, a bubble enters stage 1.
REQ-017 SHALL output 0 with ovf=0 when exp==0 (zero and denormal inputs are flushed).
REQ-018 SHALL output 0x7FFFFFFF (sign 0) or 0x80000000 (sign 1) with ovf=1 for infinity.
REQ-019 SHALL output 0 with ovf=1 for NaN.
REQ-020 SHALL, otherwise, form the 24-bit significand M={1,man} and k=exp-127+FRAC_BITS; magnitude = M<<(k-23) if k>=23, else M>>(23-k); magnitude = 0 if k<0.
REQ-021 SHALL saturate as in REQ-018 with ovf=1 when magnitude >= 2^31, except a negative value of exactly 2^31, which SHALL output 0x80000000 with ovf=0.
REQ-022 SHALL apply the sign after the magnitude step as a two's-complement negation; -0 SHALL produce 0.
REQ-023 SHALL truncate toward zero on the magnitude when AHFP_F2X_ROUND_EN is undefined.

Reset
REQ-024 SHALL, with rst=1 at a clock edge, clear both stage-valid bits, out_valid, out and ovf to 0.
REQ-025 SHALL discard in-flight operands when reset is asserted mid-operation; no result from before reset is ever presented.
REQ-026 SHALL drive in_ready=1 during and immediately after reset, since out_valid=0.

Configuration
REQ-027 SHALL, when macro AHFP_F2X_ROUND_EN is defined, round the magnitude to nearest, ties-to-even, using guard and sticky bits from the right shift.
REQ-028 SHALL apply saturation per REQ-021 when rounding carries the magnitude to 2^31.
REQ-029 SHALL keep latency and handshake identical whether or not AHFP_F2X_ROUND_EN is defined.

Verification
REQ-030 (FRAC_BITS=27) SHALL cover: in 0x3F800000, 0xBF800000, 0x3F000000 back-to-back with out_ready=1 -> out 0x08000000, 0xF8000000, 0x04000000 on consecutive cycles, each 2 cycles after acceptance, ovf=0.
REQ-031 SHALL cover: 0x41800000 (+16.0) -> 0x7FFFFFFF with ovf=1; 0xC1800000 (-16.0) -> 0x80000000 with ovf=0; 0x7F800000 -> 0x7FFFFFFF with ovf=1; 0x7FC00000 -> 0 with ovf=1.
REQ-032 SHALL cover: 0x00400000 (denormal) -> 0 with ovf=0; 0x31C00000 (1.5*2^-28) -> 0 without the macro, 0x00000001 with AHFP_F2X_ROUND_EN.
REQ-033 SHALL cover: 3 operands streaming in, out_ready=0 for 4 cycles -> in_ready=0, out frozen on the first result; after release all 3 results appear in order with no loss or duplication.
REQ-034 SHALL cover: rst pulsed for 1 cycle while 2 operands are in flight -> out_valid=0, out=0 on the next cycle, and no stale result ever emerges.
